decode_issue_stage: RTL and testbench
=====================================

// Module: decode_issue_stage
// PURPOSE
//  Instruction decode/issue stage directly upstream of the 32x32 register file.
//  - Latches a fetched MIPS instruction and decodes it.
//  - Drives the regfile read addresses and captures both read ports.
//  - Tracks destination registers that are still in flight in a 32-bit scoreboard and stalls on RAW hazards.
//  - Hands an operand packet to execute over a valid/ready handshake.
// PARAMETERS
//  TRACK_HAZARDS  1   1: scoreboard stalls enabled; 0: scoreboard forced to all zeros, never stalls.
//  LINK_REG       31  Destination register written by jal.
// PORTS
//  Clk          in   1   Clock, positive edge.
//  Reset        in   1   Synchronous, active-high.
//  InstrValid   in   1   Fetch offers Instr.
//  Instr        in   32  Instruction word.
//  InstrReady   out  1   Stage accepts Instr this cycle.
//  ReadRegister1 out 5   To regfile: rs of the held instruction.
//  ReadRegister2 out 5   To regfile: rt of the held instruction.
//  ReadData1    in   32  From regfile (combinational read).
//  ReadData2    in   32  From regfile (combinational read).
//  WbValid      in   1   Writeback retires a register write this cycle.
//  WbRegister   in   5   Register retired; clears its scoreboard bit.
//  OutValid     out  1   Operand packet valid.
//  OutReady     in   1   Execute accepts the packet.
//  OutOpA       out  32  rs value.
//  OutOpB       out  32  rt value.
//  OutImm       out  32  Sign-extended imm16 (andi/ori/xori: zero-extended).
//  OutOpcode    out  6   Opcode.
//  OutFunct     out  6   Funct field.
//  OutDest      out  5   Destination register; 0 when no write.
//  OutRegWrite  out  1   Instruction writes OutDest.
//  OutIllegal   out  1   Opcode not decoded; packet is passed on as a no-write.
// BEHAVIOUR
//  - Reset: hold reg empty, OutValid=0, all Out* data=0, scoreboard=0, InstrReady=1 on the next cycle.
//    Reset mid-operation drops any held or output instruction.
//  - Hold register (H): accepts on InstrValid&&InstrReady.
//    InstrReady = !H.valid || issue (combinational).
//  - ReadRegister1/2 = H.rs/H.rt at all times; they are 0 when H is empty.
//  - Source use:
//    - R-type: rs, rt.
//    - lw, addi, andi, ori, xori: rs.
//    - sw, beq, bne: rs, rt.
//    - j, jal: none.
//  - Destination:
//    - R-type: rd; jr (funct 0x08) does not write.
//    - lw(0x23), addi(0x08), andi(0x0c), ori(0x0d), xori(0x0e): rt.
//    - jal(0x03): LINK_REG.
//    - sw/beq/bne/j and illegal: none.
//    - Any dest==0 is forced to OutRegWrite=0.
//  - hazard = H.valid && (used rs && sb[rs] || used rt && sb[rt]).
//    sb[0] is always 0.
//  - issue = H.valid && !hazard && (!OutValid || OutReady).
//  - On issue:
//    - Out* load from decode plus ReadData1/2 sampled at that edge; OutValid=1.
//    - If the instruction writes, sb[dest] is set.
//  - Out holds stable while OutValid && !OutReady.
//  - OutValid clears on OutReady with no issue.
//  - WbValid clears sb[WbRegister] at the edge; the cleared bit is visible the next cycle.
//    No same-cycle bypass, so the regfile write has landed before the read.
//  - Same reg issued and retired in the same cycle: the set wins.
//  - Latency with no hazard and no backpressure: Instr accepted at edge N -> OutValid at edge N+1.
//    Throughput is 1 per cycle.
//  - WbValid for a register whose bit is clear: no effect.
//    WbRegister=0 is ignored.
// TESTING
//  - Reset with InstrValid=1: InstrReady=1 the cycle after Reset drops; OutValid=0 and scoreboard=0 during reset.
//  - addi $1,$0,5 (0x20010005):
//    - OutValid one cycle after accept.
//    - OutDest=1, OutRegWrite=1, OutImm=5, sb[1]=1.
//  - add $3,$1,$2 (0x00221820) issued right after, with sb[1] set:
//    - Stalls and InstrReady=0.
//    - WbValid/WbRegister=1 -> issues on the following edge with OutOpA=ReadData1.
//  - lw $4,0($3) (0x8c640000) with OutReady=0 for 3 cycles: Out* stable; next instruction waits in H; no loss or duplication.
//  - Writes to $0 (0x20000007) and jr $31 (0x03e00008): OutRegWrite=0, no scoreboard change.
//  - Opcode 0x3f: OutIllegal=1, OutRegWrite=0.
//  - Back-to-back independent instructions with OutReady=1: one issue per cycle; scoreboard set and cleared on the same reg -> stays 1.

Source files
------------

// File: rtl/decode_issue_if.sv
// decode_issue_if: fetch, regfile, writeback and execute signals of the decode/issue stage.
// The master modport is the stage itself; slave is the surrounding pipeline.
interface decode_issue_if;
    logic        InstrValid;
    logic [31:0] Instr;
    logic        InstrReady;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        WbValid;
    logic [4:0]  WbRegister;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutOpA;
    logic [31:0] OutOpB;
    logic [31:0] OutImm;
    logic [5:0]  OutOpcode;
    logic [5:0]  OutFunct;
    logic [4:0]  OutDest;
    logic        OutRegWrite;
    logic        OutIllegal;
    modport master (
        input  InstrValid, Instr, ReadData1, ReadData2, WbValid, WbRegister, OutReady,
        output InstrReady, ReadRegister1, ReadRegister2, OutValid, OutOpA, OutOpB, OutImm,
               OutOpcode, OutFunct, OutDest, OutRegWrite, OutIllegal
    );
    modport slave (
        output InstrValid, Instr, ReadData1, ReadData2, WbValid, WbRegister, OutReady,
        input  InstrReady, ReadRegister1, ReadRegister2, OutValid, OutOpA, OutOpB, OutImm,
               OutOpcode, OutFunct, OutDest, OutRegWrite, OutIllegal
    );
endinterface

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: MIPS decode/issue with a one-entry hold register, RAW scoreboard
// and a valid/ready operand packet towards execute.
module decode_issue_stage #(
    parameter bit         TRACK_HAZARDS = 1'b1,
    parameter logic [4:0] LINK_REG      = 5'd31
) (
    input logic Clk,
    input logic Reset,
    decode_issue_if.master bus
);
    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] imm;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  dest;
        logic        reg_write;
        logic        illegal;
    } pkt_t;
    logic        h_valid_q, h_valid_d, out_valid_q, out_valid_d;
    logic [31:0] h_instr_q, h_instr_d, sb_q, sb_d;
    pkt_t        out_q, out_d, dec;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, dest;
    logic        is_r, is_lw, is_logic, is_alui, is_sw, is_br, is_jal, legal;
    logic        use_rs, use_rt, hazard, issue;
    always_comb begin
        op       = h_instr_q[31:26];
        rs       = h_instr_q[25:21];
        rt       = h_instr_q[20:16];
        rd       = h_instr_q[15:11];
        funct    = h_instr_q[5:0];
        is_r     = op == 6'h00;
        is_lw    = op == 6'h23;
        is_logic = op inside {6'h0c, 6'h0d, 6'h0e};
        is_alui  = op == 6'h08 || is_logic;
        is_sw    = op == 6'h2b;
        is_br    = op inside {6'h04, 6'h05};
        is_jal   = op == 6'h03;
        legal    = is_r || is_lw || is_alui || is_sw || is_br || op == 6'h02 || is_jal;
        use_rs   = is_r || is_lw || is_alui || is_sw || is_br;
        use_rt   = is_r || is_sw || is_br;
        dest     = is_r ? (funct == 6'h08 ? 5'd0 : rd) : (is_lw || is_alui) ? rt : is_jal ? LINK_REG : 5'd0;
        dec.op_a      = bus.ReadData1;
        dec.op_b      = bus.ReadData2;
        dec.imm       = is_logic ? {16'h0, h_instr_q[15:0]} : {{16{h_instr_q[15]}}, h_instr_q[15:0]};
        dec.opcode    = op;
        dec.funct     = funct;
        dec.dest      = dest;
        dec.reg_write = dest != 5'd0;
        dec.illegal   = !legal;
        hazard = h_valid_q && (use_rs && sb_q[rs] || use_rt && sb_q[rt]);
        issue  = h_valid_q && !hazard && (!out_valid_q || bus.OutReady);
    end
    always_comb begin
        h_valid_d   = bus.InstrReady ? bus.InstrValid : h_valid_q;
        h_instr_d   = bus.InstrReady && bus.InstrValid ? bus.Instr : h_instr_q;
        out_valid_d = issue || (out_valid_q && !bus.OutReady);
        out_d       = issue ? dec : out_q;
        sb_d        = sb_q;
        if (bus.WbValid)
            sb_d[bus.WbRegister] = 1'b0;
        // Applied after the clear so an issue and a retire of the same register leave it set.
        if (issue && dec.reg_write)
            sb_d[dest] = 1'b1;
        sb_d[0] = 1'b0;
        if (!TRACK_HAZARDS)
            sb_d = '0;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            h_valid_q   <= 1'b0;
            h_instr_q   <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            sb_q        <= '0;
        end else begin
            h_valid_q   <= h_valid_d;
            h_instr_q   <= h_instr_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            sb_q        <= sb_d;
        end
    end
    assign bus.InstrReady    = !h_valid_q || issue;
    assign bus.ReadRegister1 = h_valid_q ? rs : 5'd0;
    assign bus.ReadRegister2 = h_valid_q ? rt : 5'd0;
    assign bus.OutValid      = out_valid_q;
    assign bus.OutOpA        = out_q.op_a;
    assign bus.OutOpB        = out_q.op_b;
    assign bus.OutImm        = out_q.imm;
    assign bus.OutOpcode     = out_q.opcode;
    assign bus.OutFunct      = out_q.funct;
    assign bus.OutDest       = out_q.dest;
    assign bus.OutRegWrite   = out_q.reg_write;
    assign bus.OutIllegal    = out_q.illegal;
endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: directed vectors with hand-computed packets queued for a monitor
// that pops and compares on every accepted output; regfile reads return 0xDEAD0000|reg.
module tb_decode_issue_stage;
    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] imm;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  dest;
        logic        reg_write;
        logic        illegal;
    } pkt_t;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   passed = 0;
    pkt_t exp_q[$];
    pkt_t mon_act, mon_exp;
    always #5 Clk = ~Clk;
    decode_issue_if bus();
    decode_issue_stage #(.TRACK_HAZARDS(1'b1), .LINK_REG(5'd31)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
    function automatic logic [31:0] rf(input logic [4:0] r);
        return 32'hDEAD0000 | {27'd0, r};
    endfunction
    assign bus.ReadData1 = rf(bus.ReadRegister1);
    assign bus.ReadData2 = rf(bus.ReadRegister2);
    task automatic tick;
        @(posedge Clk);
        #1;
    endtask
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] dst, input logic rw,
                        input logic ill, input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b);
        pkt_t p;
        p.op_a = a; p.op_b = b; p.imm = imm; p.opcode = op; p.funct = fn;
        p.dest = dst; p.reg_write = rw; p.illegal = ill;
        exp_q.push_back(p);
    endtask
    always @(negedge Clk) begin
        if (!Reset && bus.OutValid && bus.OutReady) begin
            mon_act = {bus.OutOpA, bus.OutOpB, bus.OutImm, bus.OutOpcode, bus.OutFunct,
                       bus.OutDest, bus.OutRegWrite, bus.OutIllegal};
            checks++;
            if (exp_q.size() == 0)
                $display("FAIL unexpected_packet: got %h expected none", mon_act);
            else begin
                mon_exp = exp_q.pop_front();
                if (mon_act === mon_exp) passed++;
                else $display("FAIL packet: got %h expected %h", mon_act, mon_exp);
            end
        end
    end
    logic [31:0] stream [5] = '{32'h20060001, 32'h20070002, 32'h34080003, 32'h38090004, 32'h200affff};
    logic [4:0]  dests  [5] = '{5'd6, 5'd7, 5'd8, 5'd9, 5'd10};
    initial begin
        bus.InstrValid = 1'b1;
        bus.Instr      = 32'h20010005;
        bus.WbValid    = 1'b0;
        bus.WbRegister = 5'd0;
        bus.OutReady   = 1'b1;
        repeat (2) tick;
        @(negedge Clk);
        check("rst_outvalid", bus.OutValid, 0);
        check("rst_sb", dut.sb_q, 0);
        check("rst_outdest", bus.OutDest, 0);
        tick;
        Reset = 1'b0;
        @(negedge Clk);
        check("ready_after_rst", bus.InstrReady, 1);
        check("outvalid_after_rst", bus.OutValid, 0);
        // addi $1,$0,5 accepted here; add $3,$1,$2 offered behind it
        tick;
        bus.Instr = 32'h00221820;
        push(6'h08, 6'h05, 5'd1, 1'b1, 1'b0, 32'h5, rf(0), rf(1));
        @(negedge Clk);
        check("latency_not_early", bus.OutValid, 0);
        check("readreg2_held_rt", bus.ReadRegister2, 1);
        tick;
        bus.InstrValid = 1'b0;
        @(negedge Clk);
        check("addi_outvalid", bus.OutValid, 1);
        check("addi_sb1", dut.sb_q[1], 1);
        check("add_stall_ready", bus.InstrReady, 0);
        tick;
        @(negedge Clk);
        check("add_stall_ready2", bus.InstrReady, 0);
        check("add_stall_outvalid", bus.OutValid, 0);
        bus.WbValid = 1'b1;
        bus.WbRegister = 5'd1;
        push(6'h00, 6'h20, 5'd3, 1'b1, 1'b0, 32'h1820, rf(1), rf(2));
        tick;
        bus.WbValid = 1'b0;
        @(negedge Clk);
        check("wb_clears_sb1", dut.sb_q[1], 0);
        check("no_bypass_outvalid", bus.OutValid, 0);
        tick;
        @(negedge Clk);
        check("add_issued", bus.OutValid, 1);
        check("add_opa", bus.OutOpA, rf(1));
        check("add_sb3", dut.sb_q[3], 1);
        bus.WbValid = 1'b1;
        bus.WbRegister = 5'd3;
        tick;
        // lw $4,0($3) then ori $5,$0,0xffff under backpressure
        bus.WbValid = 1'b0;
        bus.OutReady = 1'b0;
        bus.InstrValid = 1'b1;
        bus.Instr = 32'h8c640000;
        push(6'h23, 6'h00, 5'd4, 1'b1, 1'b0, 32'h0, rf(3), rf(4));
        tick;
        bus.Instr = 32'h3405ffff;
        push(6'h0d, 6'h3f, 5'd5, 1'b1, 1'b0, 32'h0000ffff, rf(0), rf(5));
        tick;
        bus.InstrValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("bp_outvalid", bus.OutValid, 1);
            check("bp_dest_stable", bus.OutDest, 4);
            check("bp_opa_stable", bus.OutOpA, rf(3));
            check("bp_next_waits", bus.InstrReady, 0);
            tick;
        end
        bus.OutReady = 1'b1;
        tick;
        @(negedge Clk);
        check("ori_after_bp", bus.OutDest, 5);
        tick;
        // writes to $0, jr $31, illegal opcode
        bus.InstrValid = 1'b1;
        bus.Instr = 32'h20000007;
        push(6'h08, 6'h07, 5'd0, 1'b0, 1'b0, 32'h7, rf(0), rf(0));
        tick;
        bus.Instr = 32'h03e00008;
        push(6'h00, 6'h08, 5'd0, 1'b0, 1'b0, 32'h8, rf(31), rf(0));
        tick;
        bus.Instr = 32'hfc000000;
        push(6'h3f, 6'h00, 5'd0, 1'b0, 1'b1, 32'h0, rf(0), rf(0));
        tick;
        bus.InstrValid = 1'b0;
        tick;
        @(negedge Clk);
        check("illegal_flag", bus.OutIllegal, 1);
        check("illegal_nowrite", bus.OutRegWrite, 0);
        check("sb_unchanged", dut.sb_q, 32'h00000030);
        tick;
        push(6'h08, 6'h01, 5'd6, 1'b1, 1'b0, 32'h1, rf(0), rf(6));
        push(6'h08, 6'h02, 5'd7, 1'b1, 1'b0, 32'h2, rf(0), rf(7));
        push(6'h0d, 6'h03, 5'd8, 1'b1, 1'b0, 32'h3, rf(0), rf(8));
        push(6'h0e, 6'h04, 5'd9, 1'b1, 1'b0, 32'h4, rf(0), rf(9));
        push(6'h08, 6'h3f, 5'd10, 1'b1, 1'b0, 32'hffffffff, rf(0), rf(10));
        for (int i = 0; i < 5; i++) begin
            bus.InstrValid = 1'b1;
            bus.Instr = stream[i];
            bus.WbValid = i == 1;
            bus.WbRegister = 5'd6;
            tick;
            if (i > 0) begin
                @(negedge Clk);
                check("b2b_outvalid", bus.OutValid, 1);
                check("b2b_dest", bus.OutDest, dests[i-1]);
                check("b2b_ready", bus.InstrReady, 1);
            end
        end
        bus.InstrValid = 1'b0;
        bus.WbValid = 1'b0;
        tick;
        @(negedge Clk);
        check("b2b_last_dest", bus.OutDest, 10);
        check("sext_imm", bus.OutImm, 32'hffffffff);
        check("set_wins", dut.sb_q[6], 1);
        check("sb_after_stream", dut.sb_q, 32'h000007f0);
        tick;
        bus.InstrValid = 1'b1;
        bus.Instr = 32'h0c000000;
        push(6'h03, 6'h00, 5'd31, 1'b1, 1'b0, 32'h0, rf(0), rf(0));
        tick;
        bus.InstrValid = 1'b0;
        tick;
        @(negedge Clk);
        check("jal_dest", bus.OutDest, 31);
        check("jal_sb31", dut.sb_q[31], 1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
